// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding, and the byte/half lane helpers used by lsu_align.
package lsu_ctrl_pkg;

    // Load funct3 codes
    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_DATA,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_ERR
    } lsu_state_t;

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  funct,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct)
            F_LB:    r = {{24{b[7]}}, b};
            F_LH:    r = {{16{h[15]}}, h};
            F_LW:    r = word;
            F_LBU:   r = {24'h000000, b};
            F_LHU:   r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of a freshly read word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] data,
                                                input logic [2:0]  funct,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (funct)
            F_SB: r[{off, 3'b000} +: 8] = data[7:0];
            F_SH: begin
                if (off[1]) r[31:16] = data;
                else        r[15:0]  = data;
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Misaligned halfword/word, or a funct3 with no defined access.
    function automatic logic access_error(input logic       we,
                                          input logic [2:0] funct,
                                          input logic [1:0] off);
        logic illegal;
        logic mis;
        illegal = we ? (funct > 3'b010)
                     : ((funct == 3'b011) || (funct[2:1] == 2'b11));
        mis     = ((funct[1:0] == 2'b01) && off[0]) ||
                  ((funct[1:0] == 2'b10) && (off != 2'b00));
        return illegal | mis;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side request/response bundle of the load/store unit.
// master = MEM stage, slave = lsu_ctrl.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_funct, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit: access check on the
// incoming request, load extract/extend and store merge on the latched op.
// With LSU_BYTE_STROBE_EN defined it also produces lane-replicated store
// data and the matching byte strobe.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic        chk_we,
    input  logic [2:0]  chk_funct,
    input  logic [1:0]  chk_off,
    output logic        chk_err,
    input  logic [2:0]  op_funct,
    input  logic [1:0]  op_off,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
`ifdef LSU_BYTE_STROBE_EN
    ,
    output logic [31:0] repl_data,
    output logic [3:0]  wstrb
`endif
);

    // Check, extract and merge are pure functions of the inputs.
    always_comb begin
        chk_err    = access_error(chk_we, chk_funct, chk_off);
        load_data  = load_extract(rdata, op_funct, op_off);
        merge_data = store_merge(rdata, wdata, op_funct, op_off);
    end

`ifdef LSU_BYTE_STROBE_EN
    // Replicate the sub-word across all lanes; the strobe picks the lane.
    always_comb begin
        repl_data = 32'h0000_0000;
        wstrb     = 4'b1111;
        case (op_funct)
            F_SB: begin
                repl_data = {4{wdata[7:0]}};
                wstrb     = 4'b0001 << op_off;
            end
            F_SH: begin
                repl_data = {2{wdata}};
                wstrb     = op_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                repl_data = 32'h0000_0000;
                wstrb     = 4'b1111;
            end
        endcase
    end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller in front of a synchronous-read data RAM.
// Optional build macro: LSU_BYTE_STROBE_EN (adds mem_wstrb, sub-word
// stores become single-cycle strobed writes instead of read-modify-write).
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a request
// ST_RD      | load: RAM read issued
// ST_RD_DATA | load: RAM data back, extended result returned
// ST_WR      | single-cycle write (SW, or SB/SH with byte strobes)
// ST_RMW_RD  | SB/SH: read the target word
// ST_RMW_WR  | SB/SH: write the merged word back
// ST_ERR     | misaligned or illegal funct, error response
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    lsu_ctrl_if.slave         lsu,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef LSU_BYTE_STROBE_EN
    ,
    output logic [3:0]        mem_wstrb
`endif
);

    lsu_state_t        state;
    lsu_state_t        state_nx;
    logic [2:0]        funct_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic              chk_err;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              addr_hi_unused;
`ifdef LSU_BYTE_STROBE_EN
    logic [31:0]       repl_data;
    logic [3:0]        strb;
`endif

    // Bytes above the RAM window do not take part in the access.
    assign addr_hi_unused = ^lsu.req_addr[31:ADDR_W+2];

    assign accept   = (state == ST_IDLE) && lsu.req_valid;
    // Address comes from the latch so it stays put across both RMW cycles.
    assign mem_addr = addr_q[ADDR_W+1:2];

    lsu_align u_align (
        .chk_we     (lsu.req_we),
        .chk_funct  (lsu.req_funct),
        .chk_off    (lsu.req_addr[1:0]),
        .chk_err    (chk_err),
        .op_funct   (funct_q),
        .op_off     (addr_q[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
`ifdef LSU_BYTE_STROBE_EN
        ,
        .repl_data  (repl_data),
        .wstrb      (strb)
`endif
    );

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Capture the request operands on accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            funct_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
        end else if (accept) begin
            funct_q <= lsu.req_funct;
            addr_q  <= lsu.req_addr[ADDR_W+1:0];
            wdata_q <= lsu.req_wdata;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_nx       = state;
        lsu.req_ready  = 1'b0;
        lsu.resp_valid = 1'b0;
        lsu.resp_err   = 1'b0;
        lsu.resp_rdata = 32'h0000_0000;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_wdata      = 32'h0000_0000;
`ifdef LSU_BYTE_STROBE_EN
        mem_wstrb      = 4'b0000;
`endif
        case (state)
            ST_IDLE: begin
                lsu.req_ready = 1'b1;
                if (lsu.req_valid) begin
                    if (chk_err)                  state_nx = ST_ERR;
                    else if (!lsu.req_we)         state_nx = ST_RD;
                    else if (lsu.req_funct == F_SW) state_nx = ST_WR;
                    else begin
`ifdef LSU_BYTE_STROBE_EN
                        state_nx = ST_WR;
`else
                        state_nx = ST_RMW_RD;
`endif
                    end
                end
            end
            ST_RD: begin
                mem_en   = 1'b1;
                state_nx = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                lsu.resp_valid = 1'b1;
                lsu.resp_rdata = load_data;
                state_nx       = ST_IDLE;
            end
            ST_WR: begin
                mem_we         = 1'b1;
                lsu.resp_valid = 1'b1;
`ifdef LSU_BYTE_STROBE_EN
                mem_wdata      = (funct_q == F_SW) ? wdata_q : repl_data;
                mem_wstrb      = strb;
`else
                mem_wdata      = wdata_q;
`endif
                state_nx       = ST_IDLE;
            end
            ST_RMW_RD: begin
                mem_en   = 1'b1;
                state_nx = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_we         = 1'b1;
                mem_wdata      = merge_data;
                lsu.resp_valid = 1'b1;
`ifdef LSU_BYTE_STROBE_EN
                mem_wstrb      = 4'b1111;
`endif
                state_nx       = ST_IDLE;
            end
            ST_ERR: begin
                lsu.resp_valid = 1'b1;
                lsu.resp_err   = 1'b1;
                state_nx       = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: transaction-level model schedules the expected
// per-cycle RAM and response activity, a negedge process compares it.
module tb_lsu_ctrl;

    localparam int NCYC = 1024;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_BYTE_STROBE_EN
    logic [3:0]  mem_wstrb;
`endif

    lsu_ctrl_if bus ();

    lsu_ctrl #(.ADDR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .lsu       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef LSU_BYTE_STROBE_EN
        ,
        .mem_wstrb (mem_wstrb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM driven by the DUT
    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (mem_we) begin
`ifdef LSU_BYTE_STROBE_EN
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
            ram[mem_addr] <= mem_wdata;
`endif
        end
        if (mem_en) mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected activity per cycle (key = edges seen so far)
    logic        e_valid [0:NCYC-1];
    logic        e_err   [0:NCYC-1];
    logic [31:0] e_rdata [0:NCYC-1];
    logic        e_en    [0:NCYC-1];
    logic        e_we    [0:NCYC-1];
    logic [9:0]  e_addr  [0:NCYC-1];
    logic [31:0] e_wdata [0:NCYC-1];
    logic [3:0]  e_wstrb [0:NCYC-1];

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the scheduled expectations
    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, e_valid[cyc]});
            chk("mem_en", {31'b0, mem_en}, {31'b0, e_en[cyc]});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we[cyc]});
            if (e_valid[cyc]) begin
                chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e_err[cyc]});
                chk("resp_rdata", bus.resp_rdata, e_rdata[cyc]);
            end
            if (e_en[cyc] || e_we[cyc])
                chk("mem_addr", {22'b0, mem_addr}, {22'b0, e_addr[cyc]});
            if (e_we[cyc])
                chk("mem_wdata", mem_wdata, e_wdata[cyc]);
`ifdef LSU_BYTE_STROBE_EN
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_wstrb[cyc]});
`endif
            if (bus.resp_valid) begin
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
            end
        end
    end

    // Transaction model: what the spec says happens after an accept at edge a.
    // Returns the number of cycles the operation occupies.
    task automatic model(input int a, input logic we, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] d, output int lat);
        logic [1:0]  off;
        int          widx;
        int          size;
        logic        illegal, mis;
        logic [31:0] w, v, mask, nw;
        off  = addr[1:0];
        widx = int'(addr[11:2]);
        size = int'(f[1:0]);
        if (we) illegal = (f >= 3);
        else    illegal = (f == 3) || (f >= 6);
        mis = (size == 1 && off[0]) || (size == 2 && off != 0);
        w = ref_mem[widx];
        if (illegal || mis) begin
            e_valid[a] = 1; e_err[a] = 1; e_rdata[a] = 0;
            lat = 1;
        end else if (!we) begin
            v = w >> (8 * off);
            if (size == 0) begin
                v = v & 32'hFF;
                if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 1) begin
                v = (off[1] ? (w >> 16) : w) & 32'hFFFF;
                if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            e_en[a] = 1; e_addr[a] = addr[11:2];
            e_valid[a+1] = 1; e_err[a+1] = 0; e_rdata[a+1] = v;
            lat = 2;
        end else if (size == 2) begin
            e_we[a] = 1; e_addr[a] = addr[11:2]; e_wdata[a] = d; e_wstrb[a] = 4'hF;
            e_valid[a] = 1; e_err[a] = 0; e_rdata[a] = 0;
            ref_mem[widx] = d;
            lat = 1;
        end else begin
            mask = ((size == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
            nw   = (w & ~mask) | ((d << (8 * off)) & mask);
            ref_mem[widx] = nw;
`ifdef LSU_BYTE_STROBE_EN
            e_we[a] = 1; e_addr[a] = addr[11:2];
            e_wdata[a] = (size == 0) ? (d & 32'hFF) * 32'h0101_0101 : (d & 32'hFFFF) * 32'h0001_0001;
            e_wstrb[a] = ((size == 0) ? 4'b0001 : 4'b0011) << off;
            e_valid[a] = 1; e_err[a] = 0; e_rdata[a] = 0;
            lat = 1;
`else
            e_en[a] = 1; e_addr[a] = addr[11:2];
            e_we[a+1] = 1; e_addr[a+1] = addr[11:2]; e_wdata[a+1] = nw;
            e_valid[a+1] = 1; e_err[a+1] = 0; e_rdata[a+1] = 0;
            lat = 2;
`endif
        end
    endtask

    // Present a request (called #1 after an edge), schedule, wait for completion
    task automatic issue(input logic we, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] d);
        int a;
        int lat;
        chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1; bus.req_we = we; bus.req_funct = f;
        bus.req_addr = addr; bus.req_wdata = d;
        @(posedge clk); #1;
        a = cyc;
        bus.req_valid = 0;
        model(a, we, f, addr, d, lat);
        repeat (lat) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int a;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 32'h0; ref_mem[i] = 32'h0;
            e_valid[i] = 0; e_err[i] = 0; e_rdata[i] = 0; e_en[i] = 0;
            e_we[i] = 0; e_addr[i] = 0; e_wdata[i] = 0; e_wstrb[i] = 0;
        end
        ram[16] = 32'h8081_F2F3; ref_mem[16] = 32'h8081_F2F3;
        ram[8]  = 32'h1122_3344; ref_mem[8]  = 32'h1122_3344;
        ram[12] = 32'h0BAD_F00D; ref_mem[12] = 32'h0BAD_F00D;
        ram[9]  = 32'h5566_7788; ref_mem[9]  = 32'h5566_7788;
        mem_rdata = 32'h0;
        reset = 0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct = 0;
        bus.req_addr = 0; bus.req_wdata = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1;
        @(posedge clk); #1;

        // Loads from the preloaded word at 0x40
        issue(0, 3'b000, 32'h43, 0);
        chk("lb_0x43", last_rdata, 32'hFFFF_FF80);
        issue(0, 3'b100, 32'h41, 0);
        chk("lbu_0x41", last_rdata, 32'h0000_00F2);
        issue(0, 3'b001, 32'h42, 0);
        chk("lh_0x42", last_rdata, 32'hFFFF_8081);
        issue(0, 3'b101, 32'h40, 0);
        chk("lhu_0x40", last_rdata, 32'h0000_F2F3);

        // Word store then load back
        issue(1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        issue(0, 3'b010, 32'h10, 0);
        chk("lw_0x10", last_rdata, 32'hDEAD_BEEF);

        // Sub-word stores into 0x1122_3344
        issue(1, 3'b000, 32'h22, 32'h0000_00AB);
        issue(1, 3'b001, 32'h20, 32'h0000_CAFE);
        issue(0, 3'b010, 32'h20, 0);
        chk("lw_0x20_merged", last_rdata, 32'h11AB_CAFE);

`ifdef LSU_BYTE_STROBE_EN
        issue(1, 3'b000, 32'h21, 32'h0000_005A);
        chk("strobe_sb_ram", ram[8], 32'h11AB_5AFE);
`endif

        // Error cases: misaligned and illegal funct
        issue(0, 3'b001, 32'h31, 0);
        chk("lh_mis_err", {31'b0, last_err}, 32'd1);
        chk("lh_mis_rdata", last_rdata, 32'h0);
        issue(1, 3'b010, 32'h32, 32'h1234_5678);
        chk("sw_mis_err", {31'b0, last_err}, 32'd1);
        issue(0, 3'b011, 32'h30, 0);
        chk("ld_f011_err", {31'b0, last_err}, 32'd1);
        issue(0, 3'b111, 32'h30, 0);
        issue(1, 3'b100, 32'h30, 32'hFFFF_FFFF);
        chk("st_f100_err", {31'b0, last_err}, 32'd1);
        chk("err_mem_unchanged", ram[12], 32'h0BAD_F00D);

        // Reset in the middle of a sub-word store
        chk("req_ready_pre_rst", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1; bus.req_we = 1; bus.req_funct = 3'b000;
        bus.req_addr = 32'h24; bus.req_wdata = 32'h0000_00EE;
        @(posedge clk); #1;
        a = cyc;
        bus.req_valid = 0;
`ifdef LSU_BYTE_STROBE_EN
        // Strobed SB writes in the first cycle; model it normally
        e_we[a] = 1; e_addr[a] = 10'd9; e_wdata[a] = 32'hEEEE_EEEE; e_wstrb[a] = 4'b0001;
        e_valid[a] = 1; ref_mem[9] = 32'h5566_77EE;
`else
        e_en[a] = 1; e_addr[a] = 10'd9;
`endif
        reset = 0;
        @(posedge clk); #1;
        chk("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mid_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_mid_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("rst_mid_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("req_ready_post_rst", {31'b0, bus.req_ready}, 32'd1);
`ifndef LSU_BYTE_STROBE_EN
        chk("rst_abandon_ram", ram[9], 32'h5566_7788);
`endif
        issue(0, 3'b010, 32'h24, 0);
        chk("lw_after_rst", last_rdata, ref_mem[9]);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit on the pipeline side of the data memory. It initiates accesses to the synchronous-read block RAM data memory on behalf of the MEM stage.
- Performs byte-offset alignment, sign/zero extension and misalignment detection.
- Sub-word stores (SB/SH) are done as read-modify-write over two memory cycles, so merged data always comes from a fresh RAM read.
- Presents a valid/ready request port to the pipeline and a one-cycle response pulse.

Parameters:
- ADDR_W, 10: word-address width of the data RAM. mem_addr = req_addr[ADDR_W+1:2].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  with resp_valid: misaligned or illegal funct
- resp_rdata  out  32  extended load data; 0 for stores/errors
- mem_en  out  1  RAM read enable
- mem_we  out  1  RAM write enable (full word)
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - req_ready=1 after reset release.
  - resp_valid, resp_err, mem_en and mem_we are 0; resp_rdata, mem_addr and mem_wdata are 0.
  - An in-flight operation is abandoned; no pending write is issued.
- Accept: req_valid & req_ready at edge T latches we/funct/addr/wdata. req_ready=1 only in IDLE. Requests while busy are ignored and must be held by the requester.
- FSM states: IDLE, RD, RD_DATA, WR, RMW_RD, RMW_WR, ERR.
- Error check at accept:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct for loads: 011/110/111. Illegal funct for stores: >=011.
  - An error goes to ERR. At T+1: resp_valid=1, resp_err=1, rdata=0, no memory access.
- Load path: IDLE -> RD (T+1: mem_en=1, mem_addr) -> RD_DATA (T+2).
  - At T+2 resp_valid=1, with rdata extracted from mem_rdata combinationally.
  - Byte lane = addr[1:0]; half lane = addr[1]. Little-endian.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW path: IDLE -> WR (T+1: mem_we=1, mem_wdata=wdata). resp_valid at T+1.
- SB/SH path: IDLE -> RMW_RD (T+1: mem_en=1) -> RMW_WR (T+2).
  - At T+2: mem_we=1, mem_wdata = mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]. resp_valid at T+2.
- After RD_DATA, WR, RMW_WR or ERR the FSM returns to IDLE. The next accept is possible the following cycle.
- Responses have no backpressure. resp_err=0 on success.
- mem_en and mem_we are never both 1. mem_addr is held stable through every multi-cycle operation.

Optional Feature:
- Macro: LSU_BYTE_STROBE_EN.
- When defined:
  - Adds output mem_wstrb[3:0].
  - SB/SH take the WR path with a single-cycle write, wdata replicated across lanes and the strobe selecting the lane(s). resp_valid at T+1. No RMW states.
  - SW uses wstrb=4'b1111. wstrb=0 when not writing.
- When undefined: no wstrb port, RMW path as above.

Decomposition:
- Shared package/defines:
  - funct3 constants for loads and stores, mirroring the existing L_* / S_* defines.
  - FSM state encoding.
  - Byte/half lane extract and merge functions.
- One natural sub-module: lsu_align, purely combinational. It contains the load extract/extend, store merge, and misalignment/illegal-funct check. The FSM stays in lsu_ctrl.

Test Plan:
- Preload word 0x8081_F2F3 at 0x40. LB at 0x43 -> resp at T+2, rdata=0xFFFF_FF80. LBU at 0x41 -> rdata=0x0000_00F2.
- SW 0xDEAD_BEEF at 0x10, then LW at 0x10 -> rdata=0xDEAD_BEEF. SW resp at T+1 with mem_we exactly one cycle.
- With word 0x1122_3344 at 0x20: SB 0xAB at 0x22 then SH 0xCAFE at 0x20, then LW -> 0x11AB_CAFE. Each store shows mem_en at T+1 and mem_we at T+2.
- LH at 0x31, and SW at 0x32 -> resp_err=1 at T+1, rdata=0, mem_en and mem_we never asserted, memory unchanged.
- Reset low during RMW_RD of an SB -> no mem_we on any later cycle, outputs 0, req_ready=1 after release, and a subsequent LW completes normally.
- With LSU_BYTE_STROBE_EN: SB 0x5A at 0x21 -> T+1 mem_we=1, mem_wstrb=4'b0010, mem_wdata=0x5A5A_5A5A, no mem_en.
